sm83_timer: RTL and testbench

Memory-mapped divider/timer peripheral that responds to the sm83 core's single shared-address bus, i.e. the same address, write-data and write-enable signals the top level already routes to ROM and WRAM. It implements the DIV, TIMA, TMA and TAC registers at 0xFF04–0xFF07. It raises a one-cycle interrupt request whenever TIMA overflows. The top level places it beside WRAM0 and uses `sel` to steer `r_data` into the CPU read-data mux.

---
 rtl/sm83_timer_if.sv | 12 +
 rtl/sm83_timer.sv | 97 +++++++++
 tb/tb_sm83_timer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sm83_timer_if.sv
// Bus bundle between the sm83 core's shared address/data nets and the timer block.
interface sm83_timer_if;
    logic [15:0] addr;
    logic [7:0]  w_data;
    logic        w_wen;
    logic [7:0]  r_data;
    logic        sel;
    logic        irq;

    modport master (output addr, w_data, w_wen, input r_data, sel, irq);
    modport slave  (input addr, w_data, w_wen, output r_data, sel, irq);
endinterface

// File: rtl/sm83_timer.sv
// DIV/TIMA/TMA/TAC divider-timer with delayed TMA reload and a one-cycle overflow irq.
module sm83_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input logic         clk,
    input logic         rst,
    sm83_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PENDING, RELOAD} state_t;

    state_t      state, state_nx;
    logic [15:0] div_cnt, off;
    logic [7:0]  tima, tma, tima_nx;
    logic [2:0]  tac;
    logic        t_prev, src_bit, tick_in, tick, irq_q, irq_nx;
    logic        wr_div, wr_tima, wr_tma, wr_tac;

    assign off     = bus.addr - BASE_ADDR;
    assign bus.sel = (off[15:2] == 14'd0);
    assign wr_div  = bus.w_wen & bus.sel & (off[1:0] == 2'd0);
    assign wr_tima = bus.w_wen & bus.sel & (off[1:0] == 2'd1);
    assign wr_tma  = bus.w_wen & bus.sel & (off[1:0] == 2'd2);
    assign wr_tac  = bus.w_wen & bus.sel & (off[1:0] == 2'd3);

    always_comb begin
        case (tac[1:0])
            2'b00:   src_bit = div_cnt[9];
            2'b01:   src_bit = div_cnt[3];
            2'b10:   src_bit = div_cnt[5];
            default: src_bit = div_cnt[7];
        endcase
    end

    // Falling edge of the gated source bit; DIV clears and TAC changes glitch it too.
    assign tick_in = tac[2] & src_bit;
    assign tick    = t_prev & ~tick_in;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    if (tick && !wr_tima && tima == 8'hFF) state_nx = PENDING;
            PENDING: state_nx = wr_tima ? IDLE : RELOAD;
            default: state_nx = IDLE;
        endcase
    end

    // TIMA priority: reload-hold (TMA write-through only) > CPU write > reload > tick.
    always_comb begin
        irq_nx  = (state == PENDING) && !wr_tima;
        tima_nx = tima;
        case (state)
            RELOAD:  if (wr_tma) tima_nx = bus.w_data;
            PENDING: tima_nx = (wr_tima || wr_tma) ? bus.w_data : tma;
            default: begin
                if (wr_tima)   tima_nx = bus.w_data;
                else if (tick) tima_nx = tima + 8'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 16'd0;
            tima    <= 8'd0;
            tma     <= 8'd0;
            tac     <= 3'd0;
            t_prev  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            div_cnt <= wr_div ? 16'd0 : div_cnt + 16'd1;
            tima    <= tima_nx;
            if (wr_tma) tma <= bus.w_data;
            if (wr_tac) tac <= bus.w_data[2:0];
            t_prev  <= tick_in;
            irq_q   <= irq_nx;
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        bus.r_data = 8'h00;
        if (bus.sel) begin
            case (off[1:0])
                2'd0:    bus.r_data = div_cnt[15:8];
                2'd1:    bus.r_data = tima;
                2'd2:    bus.r_data = tma;
                default: bus.r_data = {5'b11111, tac};
            endcase
        end
    end
endmodule

// File: tb/tb_sm83_timer.sv
// Directed plus randomized bench for sm83_timer against a cycle-level arithmetic model.
module tb_sm83_timer;
    localparam logic [15:0] BASE = 16'hFF04;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sm83_timer_if bus ();

    sm83_timer #(.BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state kept as plain integers.
    int m_div, m_tima, m_tma, m_tac, m_phase;   // phase: 0 normal, 1 overflowed, 2 reloaded
    bit m_prev, m_irq;
    int SRC [4] = '{9, 3, 5, 7};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_read(input int o);
        case (o)
            0:       return 8'(m_div / 256);
            1:       return 8'(m_tima);
            2:       return 8'(m_tma);
            default: return 8'(248 + m_tac);
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit wen, input logic [15:0] a, input logic [7:0] d);
        int o, n_tma;
        bit hit, tin, tk;
        if (r) begin
            m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
            m_prev = 0; m_phase = 0; m_irq = 0;
            return;
        end
        o     = int'(a) - int'(BASE);
        hit   = wen && o >= 0 && o < 4;
        tin   = ((m_tac / 4) % 2 == 1) && ((m_div >> SRC[m_tac % 4]) % 2 == 1);
        tk    = m_prev && !tin;
        n_tma = (hit && o == 2) ? int'(d) : m_tma;
        m_irq = 0;
        if (m_phase == 2) begin
            if (hit && o == 2) m_tima = int'(d);
            m_phase = 0;
        end else if (hit && o == 1) begin
            m_tima = int'(d);
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_tima = n_tma;
            m_irq = 1;
            m_phase = 2;
        end else if (tk) begin
            m_tima = (m_tima + 1) % 256;
            if (m_tima == 0) m_phase = 1;
        end
        m_tma = n_tma;
        if (hit && o == 3) m_tac = int'(d) % 8;
        m_div = (hit && o == 0) ? 0 : (m_div + 1) % 65536;
        m_prev = tin;
    endtask

    // One clock: drive, advance the model at the edge, then sweep the read path.
    task automatic step(input bit r, input bit wen, input logic [15:0] a, input logic [7:0] d);
        bit es;
        rst = r; bus.w_wen = wen; bus.addr = a; bus.w_data = d;
        @(posedge clk);
        model_edge(r, wen, a, d);
        #1;
        bus.w_wen = 1'b0;
        chk("irq", 16'(bus.irq), 16'(m_irq));
        for (int k = -1; k < 5; k++) begin
            bus.addr = 16'(int'(BASE) + k);
            #1;
            es = (k >= 0 && k < 4);
            chk($sformatf("sel%0d", k), 16'(bus.sel), 16'(es));
            chk($sformatf("rd%0d", k), 16'(bus.r_data), es ? 16'(model_read(k)) : 16'h0000);
        end
    endtask

    task automatic wr(input int o, input logic [7:0] d);
        step(1'b0, 1'b1, 16'(int'(BASE) + o), d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic rd_chk(input string tag, input int o, input logic [7:0] expv);
        bus.addr = 16'(int'(BASE) + o);
        #1;
        chk(tag, 16'(bus.r_data), 16'(expv));
    endtask

    task automatic setup_ovf(input logic [7:0] tma_v);
        int n;
        wr(3, 8'h05); wr(2, tma_v); wr(0, 8'h00); wr(1, 8'hFE);
        n = 0;
        while (m_phase != 1 && n < 3000) begin
            idle();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $error("FAIL pend_timeout observed=%0d expected=<3000", n);
        end
    endtask

    initial begin
        int r, o;
        logic [7:0] d;
        bus.w_wen = 1'b0; bus.addr = 16'h0000; bus.w_data = 8'h00;

        // Reset and reads
        repeat (3) step(1'b1, 1'b0, 16'h0000, 8'h00);
        rd_chk("rst_div", 0, 8'h00);
        rd_chk("rst_tma", 2, 8'h00);
        rd_chk("rst_tac", 3, 8'hF8);
        chk("rst_irq", 16'(bus.irq), 16'h0);
        repeat (255) idle();
        rd_chk("div_255", 0, 8'h00);
        idle();
        rd_chk("div_256", 0, 8'h01);
        bus.addr = 16'hFF08;
        #1;
        chk("ff08_sel", 16'(bus.sel), 16'h0);
        chk("ff08_rd", 16'(bus.r_data), 16'h0);

        // Basic count at 16 clk per tick
        wr(3, 8'h05); wr(2, 8'h00); wr(0, 8'h00); wr(1, 8'h00);
        repeat (159) idle();
        rd_chk("basic_9", 1, 8'h09);
        idle();
        rd_chk("basic_10", 1, 8'h0A);

        // Overflow and reload
        setup_ovf(8'hF0);
        rd_chk("ovf_zero", 1, 8'h00);
        chk("ovf_irq0", 16'(bus.irq), 16'h0);
        idle();
        rd_chk("ovf_reload", 1, 8'hF0);
        chk("ovf_irq1", 16'(bus.irq), 16'h1);
        idle();
        chk("ovf_irq_fall", 16'(bus.irq), 16'h0);
        rd_chk("ovf_hold", 1, 8'hF0);

        // Cancel reload with a TIMA write in the pending cycle
        setup_ovf(8'hF0);
        wr(1, 8'h33);
        rd_chk("cancel_tima", 1, 8'h33);
        chk("cancel_irq", 16'(bus.irq), 16'h0);
        idle();
        chk("cancel_irq2", 16'(bus.irq), 16'h0);

        // TIMA write in the reload cycle is dropped
        setup_ovf(8'hF0);
        idle();
        wr(1, 8'h44);
        rd_chk("reload_tima_wr", 1, 8'hF0);

        // TMA write in the reload cycle writes through to TIMA
        setup_ovf(8'hF0);
        idle();
        wr(2, 8'h77);
        rd_chk("reload_tma_tima", 1, 8'h77);
        rd_chk("reload_tma_tma", 2, 8'h77);

        // TMA write in the pending cycle feeds the reload
        setup_ovf(8'hF0);
        wr(2, 8'h55);
        rd_chk("pend_tma_tima", 1, 8'h55);
        chk("pend_tma_irq", 16'(bus.irq), 16'h1);

        // Glitch tick from DIV clear while the source bit is high
        wr(3, 8'h05); wr(0, 8'h00); wr(1, 8'h10);
        repeat (11) idle();
        wr(0, 8'h00);
        rd_chk("glitch_div_pre", 1, 8'h10);
        idle();
        rd_chk("glitch_div", 1, 8'h11);

        // Glitch tick from disabling TAC while the source bit is high
        wr(0, 8'h00); wr(1, 8'h20);
        repeat (11) idle();
        wr(3, 8'h01);
        rd_chk("glitch_tac_pre", 1, 8'h20);
        idle();
        rd_chk("glitch_tac", 1, 8'h21);

        // Randomized traffic, including stray addresses and occasional resets
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                step(1'b1, 1'b0, 16'h0000, 8'h00);
            end else if (r < 60) begin
                d = ($urandom_range(0, 1) == 1) ? 8'(32'hF8 | $urandom_range(0, 7)) : 8'($urandom);
                o = int'($urandom_range(0, 5)) - 1;
                step(1'b0, 1'b1, 16'(int'(BASE) + o), d);
            end else begin
                idle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
